// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to instruction memory,
// buffers returned words with their addresses, and flushes on branch redirect.
module instr_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        mem_req_q,  mem_req_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic        discard_q,  discard_d;
    logic [AW:0] count_q,    count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] store_instr_q [DEPTH];
    logic [63:0] store_pc_q    [DEPTH];

    logic ack_s;
    logic push_s;
    logic pop_s;
    logic issue_s;
    logic valid_s;

    assign valid_s = (count_q != {(AW + 1){1'b0}});

    // Next-state logic: redirect flush, request issue/retire, queue push/pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        issue_s    = 1'b0;
        ack_s      = mem_req_q & mem_ack;

        if (redirect) begin
            // Flush everything; an in-flight request keeps its bus handshake
            // but its data will be thrown away when it finally returns.
            count_d    = {(AW + 1){1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            wr_ptr_d   = {AW{1'b0}};
            fetch_pc_d = redirect_pc;
            if (ack_s) begin
                mem_req_d = 1'b0;
                discard_d = 1'b0;
            end else begin
                discard_d = mem_req_q;
            end
        end else begin
            pop_s   = valid_s & ~stall;
            push_s  = ack_s & ~discard_q;
            // With no request pending, count alone must leave room.
            issue_s = ~mem_req_q & (count_q < DEPTH_C);

            if (ack_s) begin
                mem_req_d = 1'b0;
                discard_d = 1'b0;
            end else if (issue_s) begin
                mem_req_d  = 1'b1;
                mem_addr_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 64'd4;
            end else begin
                mem_req_d = mem_req_q;
            end

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and pointer registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= 64'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 64'd0;
            discard_q  <= 1'b0;
            count_q    <= {(AW + 1){1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage; contents are don't-care whenever count is zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            store_instr_q[wr_ptr_q] <= mem_rdata;
            store_pc_q[wr_ptr_q]    <= mem_addr_q;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = valid_s;
    // Gate head data with valid so the outputs read zero during reset.
    assign instr       = valid_s ? store_instr_q[rd_ptr_q] : 32'd0;
    assign instr_pc    = valid_s ? store_pc_q[rd_ptr_q]    : 64'd0;

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entry count; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset; one clock only, no other clock domains.
REQ-004 SHALL have port mem_req  output  1  fetch request to instruction memory, registered.
REQ-005 SHALL have port mem_addr  output  64  byte address of the requested instruction, registered.
REQ-006 SHALL have port mem_ack  input  1  memory completes the current request this cycle.
REQ-007 SHALL have port mem_rdata  input  32  instruction word, valid only when mem_ack=1.
REQ-008 SHALL have port redirect  input  1  branch taken; restart fetch at redirect_pc.
REQ-009 SHALL have port redirect_pc  input  64  new fetch address, sampled when redirect=1.
REQ-010 SHALL have port stall  input  1  IF/ID register not accepting this cycle.
REQ-011 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port instr  output  32  head instruction word.
REQ-013 SHALL have port instr_pc  output  64  byte address of the head instruction.

Function
REQ-014 SHALL keep a fetch_pc register holding the address of the next request; fetch_pc advances by 4 (64-bit add, wraps modulo 2^64) on each issued request.
REQ-015 SHALL assert mem_req with mem_addr=fetch_pc when mem_req=0, no redirect this cycle, and count + pending < DEPTH; pending is 1 while mem_req=1.
REQ-016 SHALL hold mem_req high and mem_addr stable until the cycle mem_ack=1, then drop mem_req the next cycle; at most one request outstanding.
REQ-017 SHALL ignore mem_ack when mem_req=0.
REQ-018 SHALL push {mem_addr, mem_rdata} into the queue on mem_ack=1 unless the request is marked discard.
REQ-019 SHALL drive instr_valid=(count!=0), with instr and instr_pc from the head entry combinationally.
REQ-020 SHALL pop the head when instr_valid=1 and stall=0 and redirect=0.
REQ-021 SHALL allow push and pop in the same cycle with count unchanged; push onto an empty queue becomes visible the following cycle (no bypass).
REQ-022 SHALL never overflow: REQ-015 guarantees space; pop of an empty queue SHALL be a no-op.
REQ-023 On redirect=1 SHALL, next cycle: count=0, read/write pointers equal, fetch_pc=redirect_pc, instr_valid=0.
REQ-024 On redirect=1 with mem_req=1 and mem_ack=0 SHALL keep mem_req/mem_addr unchanged and set discard; the later acked word SHALL be dropped and discard cleared.
REQ-025 On redirect=1 and mem_ack=1 in the same cycle SHALL drop that word; redirect has priority over push and pop.
REQ-026 SHALL issue no new request in a redirect cycle; the first request to redirect_pc issues no earlier than the following cycle.
REQ-027 Pointers SHALL be log2(DEPTH) bits and wrap naturally; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-028 While reset=1 SHALL force mem_req=0, mem_addr=0, fetch_pc=0, count=0, pointers=0, discard=0, instr_valid=0 immediately (asynchronously).
REQ-029 instr and instr_pc SHALL read 0 during reset; queue storage need not be cleared.
REQ-030 Reset deasserting mid-transaction SHALL leave no pending request; a mem_ack arriving after reset SHALL be ignored.
REQ-031 First request after reset SHALL be mem_addr=0 on the first rising edge with reset=0.

Verification
REQ-032 Reset released, mem_ack one cycle after each mem_req, stall=0 -> instr_pc sequence 0,4,8,12 with matching words, no gaps beyond memory latency.
REQ-033 stall=1 held, 1-cycle ack memory, DEPTH=4 -> exactly 4 requests (0,4,8,12), mem_req stays 0, count=4; release stall -> 4 pops in order, fetching resumes at 16.
REQ-034 Request to 0x20 pending (ack delayed 3 cycles), redirect to 0x100 -> word for 0x20 dropped, next request mem_addr=0x100, first instr_pc=0x100.
REQ-035 redirect to 0x40 coinciding with mem_ack and stall=0 with 2 entries queued -> acked word dropped, no pop, instr_valid=0 next cycle, next fetch 0x40.
REQ-036 redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> requests 0xFFFF_FFFF_FFFF_FFFC then 0x0.
REQ-037 reset asserted while mem_req=1 and 3 entries queued -> all outputs 0 same cycle; post-reset stray mem_ack pushes nothing.
